// File: rtl/fifo_out_hold_gen_pkg.sv
// fifo_out_hold_gen_pkg
// Shared definitions for the event FIFO hold logic: FSM state encoding and
// default FIFO geometry / hold thresholds. The input-side hold FSM and the
// FIFO wrapper use the same defaults.
package fifo_out_hold_gen_pkg;

    localparam int DEPTH_W_DEF  = 9;    // FIFO depth = 2**DEPTH_W_DEF words
    localparam int HOLD_ON_DEF  = 448;  // hold asserts at/above this occupancy
    localparam int HOLD_OFF_DEF = 256;  // hold may release at/below this occupancy

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_HOLD_MIN  = 2'b01,
        ST_HOLD_WAIT = 2'b10
    } hold_state_e;

endpackage

// File: rtl/fifo_out_hold_gen_if.sv
// fifo_out_hold_gen_if
// Strobe/status bundle between the FIFO read side and fifo_out_hold_gen.
//   master : drives wr/wr_ee/rd/rd_ee, observes hold and FIFO status
//   slave  : the hold generator
interface fifo_out_hold_gen_if
    import fifo_out_hold_gen_pkg::*;
#(
    parameter int DEPTH_W = DEPTH_W_DEF,
    parameter int EVCNT_W = 8
);
    logic               wr;
    logic               wr_ee;
    logic               rd;
    logic               rd_ee;
    logic               hold;
    logic [DEPTH_W:0]   occupancy;
    logic [EVCNT_W-1:0] ev_count;
    logic               ev_avail;
    logic               overflow;
    logic               underflow;

    modport master (
        output wr, wr_ee, rd, rd_ee,
        input  hold, occupancy, ev_count, ev_avail, overflow, underflow
    );

    modport slave (
        input  wr, wr_ee, rd, rd_ee,
        output hold, occupancy, ev_count, ev_avail, overflow, underflow
    );
endinterface

// File: rtl/fifo_out_hold_gen_sat_updown_counter.sv
// sat_updown_counter
// Saturating up/down counter, range 0..MAX. inc and dec together is a no-op.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   inc_i, dec_i   count strobes
//   cnt_o          registered count
//   cnt_d_o        next-state count (for same-edge threshold decisions)
//   ovf_o, udf_o   inc refused at MAX / dec refused at 0 (combinational)
module sat_updown_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_d_o,
    output logic         ovf_o,
    output logic         udf_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        ovf_o = inc_i & ~dec_i & (cnt_q == MAX);
        udf_o = dec_i & ~inc_i & (cnt_q == '0);
        cnt_d = cnt_q;
        if (inc_i & ~dec_i & ~ovf_o)
            cnt_d = cnt_q + W'(1);
        else if (dec_i & ~inc_i & ~udf_o)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;
endmodule

// File: rtl/fifo_out_hold_gen.sv
// fifo_out_hold_gen
// Tracks event-FIFO occupancy and buffered complete events from write/read
// strobes and produces the upstream back-pressure 'hold' with hysteresis
// (assert at >= HOLD_ON, release at <= HOLD_OFF) and a minimum high time of
// MIN_HOLD cycles.
// Ports:
//   clock_i, reset_i   clock, synchronous active-high reset
//   bus (slave)        wr/wr_ee/rd/rd_ee in; hold, occupancy, ev_count,
//                      ev_avail, overflow, underflow out (all registered)
//   hold_cycles_o      (HOLD_STATS_EN only) saturating count of hold-high cycles
//   hold_events_o      (HOLD_STATS_EN only) saturating count of hold assertions
// Optional feature macro: HOLD_STATS_EN
module fifo_out_hold_gen
    import fifo_out_hold_gen_pkg::*;
#(
    parameter int DEPTH_W  = DEPTH_W_DEF,
    parameter int HOLD_ON  = HOLD_ON_DEF,
    parameter int HOLD_OFF = HOLD_OFF_DEF,
    parameter int MIN_HOLD = 8,
    parameter int EVCNT_W  = 8
) (
    input  logic                clock_i,
    input  logic                reset_i,
    fifo_out_hold_gen_if.slave  bus
`ifdef HOLD_STATS_EN
    ,
    output logic [31:0]         hold_cycles_o,
    output logic [15:0]         hold_events_o
`endif
);
    localparam logic [DEPTH_W:0] DEPTH  = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0] ON_TH  = HOLD_ON[DEPTH_W:0];
    localparam logic [DEPTH_W:0] OFF_TH = HOLD_OFF[DEPTH_W:0];
    localparam int               TW     = $clog2(MIN_HOLD + 1);
    localparam logic [TW-1:0]    T_LOAD = TW'(MIN_HOLD - 1);

    logic [DEPTH_W:0]   occ_q, occ_d;
    logic               occ_ovf, occ_udf;
    logic [EVCNT_W-1:0] ev_q, ev_d;
    logic               ev_sat, ev_empty;
    logic               wr_acc, rd_acc;
    logic               ovf_q, udf_q, ev_avail_q, hold_q;
    hold_state_e        state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;

    sat_updown_counter #(.W(DEPTH_W + 1), .MAX(DEPTH)) u_occ (
        .clk_i(clock_i), .rst_i(reset_i),
        .inc_i(bus.wr), .dec_i(bus.rd),
        .cnt_o(occ_q), .cnt_d_o(occ_d),
        .ovf_o(occ_ovf), .udf_o(occ_udf)
    );

    // A strobe refused by the occupancy counter must not move ev_count.
    assign wr_acc = bus.wr & ~occ_ovf;
    assign rd_acc = bus.rd & ~occ_udf;

    sat_updown_counter #(.W(EVCNT_W)) u_ev (
        .clk_i(clock_i), .rst_i(reset_i),
        .inc_i(wr_acc & bus.wr_ee), .dec_i(rd_acc & bus.rd_ee),
        .cnt_o(ev_q), .cnt_d_o(ev_d),
        .ovf_o(ev_sat), .udf_o(ev_empty)
    );

    // Saturation / decrement-at-zero of ev_count are silent.
    logic unused_ev_err;
    assign unused_ev_err = ev_sat | ev_empty;

    // HOLD_WAIT always contributes at least one hold-high cycle, so HOLD_MIN
    // is left one tick early (timer reaching 1) to make the shortest hold
    // exactly MIN_HOLD cycles. With MIN_HOLD==1 HOLD_MIN is skipped.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_RUN: begin
                if (occ_d >= ON_TH) begin
                    state_d = (MIN_HOLD > 1) ? ST_HOLD_MIN : ST_HOLD_WAIT;
                    timer_d = T_LOAD;
                end
            end
            ST_HOLD_MIN: begin
                if (timer_q <= TW'(1)) begin
                    state_d = ST_HOLD_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_HOLD_WAIT: begin
                if (occ_d <= OFF_TH) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_RUN;
            timer_q    <= '0;
            hold_q     <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            ev_avail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            hold_q     <= (state_d != ST_RUN);
            ovf_q      <= ovf_q | occ_ovf;
            udf_q      <= udf_q | occ_udf;
            ev_avail_q <= (ev_d != '0);
        end
    end

    assign bus.hold      = hold_q;
    assign bus.occupancy = occ_q;
    assign bus.ev_count  = ev_q;
    assign bus.ev_avail  = ev_avail_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;

`ifdef HOLD_STATS_EN
    logic [31:0] hcyc_q;
    logic [15:0] hevt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hcyc_q <= '0;
            hevt_q <= '0;
        end else begin
            if (hold_q && hcyc_q != '1)
                hcyc_q <= hcyc_q + 32'd1;
            if (state_q == ST_RUN && state_d != ST_RUN && hevt_q != '1)
                hevt_q <= hevt_q + 16'd1;
        end
    end

    assign hold_cycles_o = hcyc_q;
    assign hold_events_o = hevt_q;
`endif
endmodule
